// File: rtl/palette_loader_if.sv
// Avalon-MM bus between the palette loader (master) and the palette register file (slave).
interface palette_loader_if;
  logic [4:0]  AVM_ADDR;
  logic [31:0] AVM_WRITEDATA;
  logic [3:0]  AVM_BYTE_EN;
  logic        AVM_WRITE;
  logic        AVM_READ;
  logic        AVM_CS;
  logic [31:0] AVM_READDATA;
  logic        AVM_WAITREQUEST;

  modport master (
    output AVM_ADDR, AVM_WRITEDATA, AVM_BYTE_EN, AVM_WRITE, AVM_READ, AVM_CS,
    input  AVM_READDATA, AVM_WAITREQUEST
  );

  modport slave (
    input  AVM_ADDR, AVM_WRITEDATA, AVM_BYTE_EN, AVM_WRITE, AVM_READ, AVM_CS,
    output AVM_READDATA, AVM_WAITREQUEST
  );
endinterface

// File: rtl/palette_loader.sv
// Streams colors into consecutive palette addresses over Avalon-MM, with an
// optional readback pass that records the first mismatching address.
module palette_loader #(
  parameter int READ_LATENCY = 1
) (
  input  logic             CLK_100,
  input  logic             RESET,
  input  logic             start,
  input  logic [4:0]       base_addr,
  input  logic [5:0]       count,
  input  logic             verify,
  input  logic             color_valid,
  input  logic [23:0]      color_data,
  output logic             color_ready,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [4:0]       err_addr,
  palette_loader_if.master avm
);
  typedef enum logic [2:0] {IDLE, FETCH, WRITE, RD_ISSUE, RD_WAIT, DONE} state_t;

  state_t      state_q, state_d;
  logic [4:0]  base_q, base_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        verify_q, verify_d;
  logic [5:0]  i_q, i_d;
  logic [5:0]  j_q, j_d;
  logic [23:0] hold_q, hold_d;
  logic [2:0]  lat_q, lat_d;
  logic        error_q, error_d;
  logic [4:0]  err_addr_q, err_addr_d;
  logic        shadow_we;
  logic [23:0] shadow_q [32];
  logic [5:0]  i_inc, j_inc;
  logic [4:0]  wr_addr, rd_addr;
  logic        unused_rdata_hi;

  assign i_inc   = i_q + 6'd1;
  assign j_inc   = j_q + 6'd1;
  assign wr_addr = base_q + i_q[4:0];
  assign rd_addr = base_q + j_q[4:0];
  assign unused_rdata_hi = ^avm.AVM_READDATA[31:24];

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    cnt_d      = cnt_q;
    verify_d   = verify_q;
    i_d        = i_q;
    j_d        = j_q;
    hold_d     = hold_q;
    lat_d      = lat_q;
    error_d    = error_q;
    err_addr_d = err_addr_q;
    shadow_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          base_d     = base_addr;
          cnt_d      = count;
          verify_d   = verify;
          error_d    = 1'b0;
          err_addr_d = 5'd0;
          i_d        = 6'd0;
          j_d        = 6'd0;
          state_d    = (count == 6'd0) ? DONE : FETCH;
        end
      end
      FETCH: begin
        if (color_valid) begin
          hold_d    = color_data;
          shadow_we = 1'b1;
          state_d   = WRITE;
        end
      end
      WRITE: begin
        if (!avm.AVM_WAITREQUEST) begin
          i_d = i_inc;
          if (i_inc == cnt_q) begin
            j_d     = 6'd0;
            state_d = verify_q ? RD_ISSUE : DONE;
          end else begin
            state_d = FETCH;
          end
        end
      end
      RD_ISSUE: begin
        if (!avm.AVM_WAITREQUEST) begin
          lat_d   = 3'(READ_LATENCY);
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        lat_d = lat_q - 3'd1;
        // lat_q==1 means this edge is the one where read data is valid
        if (lat_q == 3'd1) begin
          if ((avm.AVM_READDATA[23:0] != shadow_q[j_q[4:0]]) && !error_q) begin
            error_d    = 1'b1;
            err_addr_d = rd_addr;
          end
          j_d     = j_inc;
          state_d = (j_inc == cnt_q) ? DONE : RD_ISSUE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK_100) begin
    if (RESET) begin
      state_q    <= IDLE;
      base_q     <= 5'd0;
      cnt_q      <= 6'd0;
      verify_q   <= 1'b0;
      i_q        <= 6'd0;
      j_q        <= 6'd0;
      hold_q     <= 24'd0;
      lat_q      <= 3'd0;
      error_q    <= 1'b0;
      err_addr_q <= 5'd0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      cnt_q      <= cnt_d;
      verify_q   <= verify_d;
      i_q        <= i_d;
      j_q        <= j_d;
      hold_q     <= hold_d;
      lat_q      <= lat_d;
      error_q    <= error_d;
      err_addr_q <= err_addr_d;
    end
  end

  // Shadow copy of every loaded entry, used as the reference during readback
  always_ff @(posedge CLK_100) begin
    if (shadow_we) shadow_q[i_q[4:0]] <= color_data;
  end

  assign color_ready       = (state_q == FETCH);
  assign busy              = (state_q != IDLE);
  assign done              = (state_q == DONE);
  assign error             = error_q;
  assign err_addr          = err_addr_q;
  assign avm.AVM_WRITE     = (state_q == WRITE);
  assign avm.AVM_READ      = (state_q == RD_ISSUE);
  assign avm.AVM_CS        = (state_q == WRITE) || (state_q == RD_ISSUE);
  assign avm.AVM_ADDR      = (state_q == WRITE) ? wr_addr :
                             (state_q == RD_ISSUE) ? rd_addr : 5'd0;
  assign avm.AVM_WRITEDATA = (state_q == WRITE) ? {8'h00, hold_q} : 32'd0;
  assign avm.AVM_BYTE_EN   = (state_q == WRITE) ? 4'b0111 : 4'b0000;
endmodule

// File: doc/palette_loader.md
# palette_loader

Avalon-MM master that bulk-loads color entries into the 8x4 color palette register file over its 5-bit-address slave port. A host pulses `start` with a base address and entry count; colors arrive on a valid/ready stream and each one is written to consecutive palette addresses. An optional verify pass reads every written entry back and flags the first mismatch. The block sits between the sprite/tile setup logic and the palette slave on the CLK_100 domain.

## Interface
- `READ_LATENCY`, default 1: clock edges from the edge where a read is accepted to the edge where `AVM_READDATA` is sampled (1..4).
- `CLK_100`  in  1  system clock; all logic is on its rising edge.
- `RESET`  in  1  synchronous, active-high reset.
- `start`  in  1  single-cycle command strobe; accepted only in IDLE.
- `base_addr`  in  5  first palette address: [4:2] palette, [1:0] color index.
- `count`  in  6  number of entries to load, 0..32.
- `verify`  in  1  when high at `start`, run the readback pass.
- `color_valid`  in  1  stream data valid.
- `color_data`  in  24  {R[23:16], G[15:8], B[7:0]}.
- `color_ready`  out  1  stream ready; a transfer occurs when valid and ready are both high.
- `busy`  out  1  high from the cycle after `start` is accepted until DONE is exited.
- `done`  out  1  one-cycle completion pulse.
- `error`  out  1  sticky verify-mismatch flag; cleared on the next accepted `start`.
- `err_addr`  out  5  palette address of the first mismatch.
- `AVM_ADDR`  out  5  slave address.
- `AVM_WRITEDATA`  out  32  {8'h00, color}.
- `AVM_BYTE_EN`  out  4  fixed at 4'b0111 during a write; 4'b0000 otherwise.
- `AVM_WRITE`, `AVM_READ`, `AVM_CS`  out  1 each  Avalon strobes.
- `AVM_READDATA`  in  32  read data; only bits [23:0] are compared.
- `AVM_WAITREQUEST`  in  1  slave stall; tie low for the palette slave.

## Operation
- **Latched command:** on `start` in IDLE, latch `base_addr`, `count` and `verify`, clear `error`/`err_addr`, set `i=0`, and go to FETCH. If `count==0`, go directly to DONE instead. `start` outside IDLE is ignored.
- **Address generation:** the address for entry k is `(base + k) mod 32`, a 5-bit wrap. Address 31 is followed by address 0.
- **FETCH:**
  - `color_ready=1`.
  - On a transfer, store `color_data` into the hold register and into `shadow[i]` (32x24 internal buffer), then go to WRITE.
- **WRITE:**
  - Drive `AVM_CS=1`, `AVM_WRITE=1`, `AVM_ADDR=base+i`, `AVM_WRITEDATA={8'h00,hold}`, `AVM_BYTE_EN=4'b0111`.
  - All signals are held stable while `AVM_WAITREQUEST=1`.
  - On an edge with waitrequest low, the write is accepted and `i++`.
  - If `i==count` after the increment: go to RD_ISSUE with `j=0` when verify is set, else go to DONE. Otherwise go to FETCH.
- **RD_ISSUE:**
  - Drive `AVM_CS=1`, `AVM_READ=1`, `AVM_ADDR=base+j`, held while waitrequest is high.
  - On acceptance, go to RD_WAIT with the latency counter loaded to `READ_LATENCY`.
- **RD_WAIT:**
  - All strobes are 0. Decrement the counter.
  - At the edge where it reaches 0, sample `AVM_READDATA[23:0]` and compare it with `shadow[j]`.
  - On mismatch with `error==0`: set `error=1` and `err_addr=base+j`. Later mismatches do not overwrite.
  - Then `j++`. If `j==count`, go to DONE; else go to RD_ISSUE.
- **DONE:** `done=1` for exactly one cycle, then go to IDLE.
- **Strobe exclusivity:** at most one of `AVM_WRITE`/`AVM_READ` is high. `AVM_CS` is high exactly when one of them is.
- **Reset:** IDLE; all outputs 0; `i`, `j`, hold and counters 0. Reset mid-transfer drops the strobes on the next edge. No partial completion is reported.

## Timing
- `start` at edge t: `busy=1` from t+1. If `count==0`, `done=1` at t+1 and `busy=0` at t+2.
- Write phase, no stalls: FETCH and WRITE alternate, giving 2 cycles per entry with the stream always valid.
- Read phase: (1 + `READ_LATENCY`) cycles per entry without stalls.
- Write-only load of N entries with the stream always valid: the last write is accepted at edge t+2N, `done` is high in cycle t+2N+1, and `busy` drops at t+2N+2.
- `color_ready` is combinational from state only, never from `color_valid`.
- `error`/`err_addr` are stable from the update edge until the next accepted `start` or reset.

## Test plan
- **Basic load:** `base=5`, `count=3`, `verify=0`, stream 0x112233/0x445566/0x778899 always valid -> three writes at addresses 5, 6, 7 with data 0x00112233..., `BYTE_EN=0111`; `done` pulses 7 cycles after `start`.
- **Wrap-around with verify:** `base=30`, `count=4`, `verify=1`, palette slave model attached -> writes to 30, 31, 0, 1; reads to the same four addresses; `error=0`.
- **Injected corruption:** the slave model corrupts address 31 and address 0 -> `error=1` and `err_addr=31` (first mismatch only).
- **Stall handling:** `AVM_WAITREQUEST` held high for 3 cycles on the second write and on the first read -> address, data and strobes are held stable; one transfer each; correct completion.
- **Stream gaps and zero count:** `color_valid` toggles every other cycle -> no write is issued without data. `count=0` -> no bus activity and `done` at t+1.
- **Mid-operation reset and ignored start:** `RESET` asserted during the write phase -> outputs 0 next edge; a later `start` runs cleanly. A `start` pulsed while busy is ignored.
